// File: rtl/game_round_scheduler.sv
// rtl/game_round_scheduler.sv - self-timed round sequencer driving one Game_State instance (optional watchdog: ROUND_TIMEOUT_EN)
module game_round_scheduler #(
    parameter int COUNTER_SIZE = 4,
    parameter int NUM_SLOTS    = 8,
    parameter int SLOT_W       = $clog2(NUM_SLOTS),
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    cfg_we,
    input  logic [SLOT_W-1:0]       cfg_addr,
    input  logic [1:0]              cfg_control,
    input  logic [COUNTER_SIZE-1:0] cfg_value,
    input  logic [SLOT_W:0]         num_rounds,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    game_rst,
    output logic [1:0]              control,
    output logic [COUNTER_SIZE-1:0] i_value,
    output logic                    INIT,
    input  logic [1:0]              who,
    input  logic                    gameover,
    output logic                    res_valid,
    output logic [SLOT_W-1:0]       res_slot,
    output logic                    res_win,
    output logic                    res_timeout,
    output logic [SLOT_W:0]         win_tally,
    output logic [SLOT_W:0]         lose_tally
);
    localparam int RW = SLOT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_RUN, S_REPORT, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [RW-1:0]           r_rounds;
    logic [RW-1:0]           w_rounds_clamped;
    logic [SLOT_W-1:0]       r_ptr;
    logic [1:0]              r_tbl_ctrl [NUM_SLOTS];
    logic [COUNTER_SIZE-1:0] r_tbl_val  [NUM_SLOTS];
    logic [1:0]              r_control;
    logic [COUNTER_SIZE-1:0] r_value;
    logic [RW-1:0]           r_win_tally;
    logic [RW-1:0]           r_lose_tally;
    logic                    r_res_win;
    logic                    r_gameover_q;
    logic                    w_go_edge;
    logic                    w_tmo;
    logic                    w_last;
    logic                    w_round_won;

    assign w_rounds_clamped = (num_rounds > RW'(NUM_SLOTS)) ? RW'(NUM_SLOTS) : num_rounds;
    assign w_go_edge        = gameover & ~r_gameover_q;
    assign w_last           = ({1'b0, r_ptr} == (r_rounds - RW'(1)));
    assign w_round_won      = w_go_edge & (who == 2'b10);

`ifdef ROUND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_res_tmo;

    // Counts RUN cycles; ARM always precedes RUN, so clearing there restarts each round.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tmo_cnt <= '0;
            r_res_tmo <= 1'b0;
        end else begin
            if (r_state == S_ARM)
                r_tmo_cnt <= '0;
            else if (r_state == S_RUN)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (r_state == S_RUN && w_next == S_REPORT)
                r_res_tmo <= ~w_go_edge;
        end
    end

    assign w_tmo       = (r_state == S_RUN) && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign res_timeout = res_valid & r_res_tmo;
`else
    assign w_tmo       = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = (w_rounds_clamped == '0) ? S_DONE : S_LOAD;
            S_LOAD:   w_next = S_ARM;
            S_ARM:    w_next = S_RUN;
            S_RUN:    if (w_go_edge || w_tmo) w_next = S_REPORT;
            S_REPORT: w_next = w_last ? S_DONE : S_LOAD;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rounds     <= '0;
            r_ptr        <= '0;
            r_control    <= '0;
            r_value      <= '0;
            r_win_tally  <= '0;
            r_lose_tally <= '0;
            r_res_win    <= 1'b0;
            r_gameover_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_tbl_ctrl[i] <= '0;
                r_tbl_val[i]  <= '0;
            end
        end else begin
            r_gameover_q <= gameover;
            if (r_state == S_IDLE) begin
                if (cfg_we) begin
                    r_tbl_ctrl[cfg_addr] <= cfg_control;
                    r_tbl_val[cfg_addr]  <= cfg_value;
                end
                if (start) begin
                    r_rounds     <= w_rounds_clamped;
                    r_ptr        <= '0;
                    r_win_tally  <= '0;
                    r_lose_tally <= '0;
                end
            end
            if (r_state == S_LOAD) begin
                r_control <= r_tbl_ctrl[r_ptr];
                r_value   <= r_tbl_val[r_ptr];
            end
            // who is sampled in the same cycle as the gameover edge.
            if (r_state == S_RUN && w_next == S_REPORT) begin
                r_res_win <= w_round_won;
                if (w_round_won) begin
                    if (r_win_tally != '1) r_win_tally <= r_win_tally + RW'(1);
                end else begin
                    if (r_lose_tally != '1) r_lose_tally <= r_lose_tally + RW'(1);
                end
            end
            if (r_state == S_REPORT && !w_last)
                r_ptr <= r_ptr + SLOT_W'(1);
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign game_rst   = ~((r_state == S_ARM) || (r_state == S_RUN));
    assign INIT       = (r_state == S_ARM);
    assign res_valid  = (r_state == S_REPORT);
    assign res_slot   = res_valid ? r_ptr : '0;
    assign res_win    = res_valid & r_res_win;
    assign control    = r_control;
    assign i_value    = r_value;
    assign win_tally  = r_win_tally;
    assign lose_tally = r_lose_tally;
endmodule

// File: tb/tb_game_round_scheduler.sv
// tb/tb_game_round_scheduler.sv - scoreboard bench for game_round_scheduler
module tb_game_round_scheduler;
    localparam int CS = 4;
    localparam int NS = 8;
    localparam int SW = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_addr = '0;
    logic [1:0]    cfg_control = '0;
    logic [CS-1:0] cfg_value = '0;
    logic [SW:0]   num_rounds = '0;
    logic          start = 1'b0;
    logic          busy, done, game_rst, INIT, res_valid, res_win, res_timeout;
    logic [1:0]    control;
    logic [CS-1:0] i_value;
    logic [1:0]    who = 2'b00;
    logic          gameover = 1'b0;
    logic [SW-1:0] res_slot;
    logic [SW:0]   win_tally, lose_tally;

    game_round_scheduler #(.COUNTER_SIZE(CS), .NUM_SLOTS(NS), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_l(rst_l), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_control(cfg_control), .cfg_value(cfg_value), .num_rounds(num_rounds),
        .start(start), .busy(busy), .done(done), .game_rst(game_rst),
        .control(control), .i_value(i_value), .INIT(INIT), .who(who),
        .gameover(gameover), .res_valid(res_valid), .res_slot(res_slot),
        .res_win(res_win), .res_timeout(res_timeout), .win_tally(win_tally),
        .lose_tally(lose_tally)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] slot;
        logic          win;
        logic          tmo;
    } res_t;

    res_t       q_res[$];
    logic [5:0] q_init[$];
    logic [1:0] m_ctrl [NS];
    logic [3:0] m_val  [NS];
    int         checks = 0;
    int         errors = 0;
    int         init_cnt = 0;
    int         res_cnt = 0;
    res_t       mon_er;
    logic [5:0] mon_ei;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected INIT configuration and round results as the DUT presents them.
    always @(negedge clk) begin
        if (rst_l) begin
            if (INIT) begin
                init_cnt++;
                check("init_game_rst", 32'(game_rst), 32'd0);
                if (q_init.size() == 0) begin
                    check("init_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_ei = q_init.pop_front();
                    check("init_cfg", 32'({control, i_value}), 32'(mon_ei));
                end
            end
            if (res_valid) begin
                res_cnt++;
                check("res_game_rst", 32'(game_rst), 32'd1);
                if (q_res.size() == 0) begin
                    check("res_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_er = q_res.pop_front();
                    check("res_slot", 32'(res_slot), 32'(mon_er.slot));
                    check("res_win", 32'(res_win), 32'(mon_er.win));
                    check("res_timeout", 32'(res_timeout), 32'(mon_er.tmo));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int a, input logic [1:0] c, input logic [3:0] v);
        cfg_we = 1'b1; cfg_addr = SW'(a); cfg_control = c; cfg_value = v;
        tick();
        cfg_we = 1'b0;
        m_ctrl[a] = c;
        m_val[a]  = v;
    endtask

    task automatic wait_init();
        bit ok = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (INIT) begin ok = 1; break; end
        end
        check("init_seen", 32'(ok), 32'd1);
    endtask

    function automatic logic [1:0] lose_who();
        case ($urandom % 3)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // mode: 0 normal, 1 gameover high entering RUN of round 0, 2 start/cfg_we pulsed mid-RUN
    // pat: <0 random outcomes, else bit r = win of round r
    task automatic run_seq(input int n, input int mode, input int pat);
        int  rounds;
        int  wins = 0;
        int  losses = 0;
        int  cyc = 0;
        bit  w [NS];
        res_t e;
        rounds = (n > NS) ? NS : n;
        for (int r = 0; r < rounds; r++) begin
            w[r] = (pat < 0) ? 1'($urandom % 2) : 1'((pat >> r) & 1);
            if (w[r]) wins++; else losses++;
            q_init.push_back({m_ctrl[r], m_val[r]});
            e.slot = SW'(r); e.win = w[r]; e.tmo = 1'b0;
            q_res.push_back(e);
        end
        num_rounds = (SW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cyc++;
            if (INIT) break;
        end
        check("init_latency", 32'(cyc), 32'd2);
        for (int r = 0; r < rounds; r++) begin
            if (r > 0) wait_init();
            if (mode == 1 && r == 0) begin
                gameover = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("held_no_report", 32'(res_valid), 32'd0);
                end
                gameover = 1'b0;
                @(negedge clk);
            end
            if (mode == 2 && r == 0) begin
                @(negedge clk);
                start = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
                cfg_control = ~m_ctrl[0]; cfg_value = ~m_val[0]; num_rounds = 1;
                @(negedge clk);
                start = 1'b0; cfg_we = 1'b0;
                check("busy_mid_run", 32'(busy), 32'd1);
                check("no_init_mid_run", 32'(INIT), 32'd0);
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
            who = w[r] ? 2'b10 : lose_who();
            gameover = 1'b1;
            @(negedge clk);
            check("res_latency", 32'(res_valid), 32'd1);
            gameover = 1'b0;
            who = 2'b00;
        end
        if (rounds > 0) begin
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd1);
            check("done_game_rst", 32'(game_rst), 32'd1);
            check("win_tally", 32'(win_tally), 32'(wins));
            check("lose_tally", 32'(lose_tally), 32'(losses));
            @(negedge clk);
            check("busy_after", 32'(busy), 32'd0);
            check("done_single", 32'(done), 32'd0);
        end
        check("queues_drained", 32'(q_res.size() + q_init.size()), 32'd0);
        tick();
    endtask

    initial begin
        int i0, r0;
        res_t e;
        for (int i = 0; i < NS; i++) begin m_ctrl[i] = '0; m_val[i] = '0; end

        // reset state
        repeat (2) @(negedge clk);
        check("rst_game_rst", 32'(game_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_init", 32'(INIT), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_tallies", 32'({win_tally, lose_tally}), 32'd0);
        rst_l = 1'b1;
        tick();

        // single winning round
        write_slot(0, 2'd0, 4'd0);
        run_seq(1, 0, 1);

        // lose, lose, win
        write_slot(0, 2'd2, 4'd15);
        write_slot(1, 2'd3, 4'd1);
        write_slot(2, 2'd1, 4'd0);
        i0 = init_cnt;
        run_seq(3, 0, 3'b100);
        check("init_pulses", 32'(init_cnt - i0), 32'd3);

        // zero rounds
        i0 = init_cnt; r0 = res_cnt;
        num_rounds = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        @(negedge clk);
        check("zero_idle", 32'(busy), 32'd0);
        check("zero_no_init", 32'(init_cnt - i0), 32'd0);
        check("zero_no_res", 32'(res_cnt - r0), 32'd0);
        tick();

        // clamped to NUM_SLOTS
        for (int i = 0; i < NS; i++) write_slot(i, 2'($urandom), 4'($urandom));
        r0 = res_cnt;
        run_seq(15, 0, -1);
        check("clamp_rounds", 32'(res_cnt - r0), 32'd8);

        // disturbances inside RUN
        run_seq(2, 2, -1);
        run_seq(3, 1, -1);

        // randomized sequences
        repeat (5) begin
            for (int i = 0; i < NS; i++)
                if ($urandom % 2) write_slot(i, 2'($urandom), 4'($urandom));
            run_seq($urandom_range(1, 15), 0, -1);
        end

`ifdef ROUND_TIMEOUT_EN
        begin
            int cyc = 0;
            write_slot(0, 2'd1, 4'd7);
            q_init.push_back({m_ctrl[0], m_val[0]});
            e.slot = '0; e.win = 1'b0; e.tmo = 1'b1;
            q_res.push_back(e);
            num_rounds = 1;
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_init();
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                cyc++;
                if (res_valid) break;
            end
            check("timeout_latency", 32'(cyc), 32'(TO + 1));
            @(negedge clk);
            check("timeout_lose_tally", 32'(lose_tally), 32'd1);
            check("timeout_win_tally", 32'(win_tally), 32'd0);
            tick();
        end
`endif

        // reset pulse during round 1 after round 0 won
        write_slot(0, 2'd3, 4'd9);
        write_slot(1, 2'd2, 4'd5);
        q_init.push_back({m_ctrl[0], m_val[0]});
        q_init.push_back({m_ctrl[1], m_val[1]});
        e.slot = '0; e.win = 1'b1; e.tmo = 1'b0;
        q_res.push_back(e);
        num_rounds = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_init();
        @(negedge clk);
        who = 2'b10; gameover = 1'b1;
        @(negedge clk);
        gameover = 1'b0; who = 2'b00;
        wait_init();
        @(negedge clk);
        r0 = res_cnt;
        rst_l = 1'b0;
        #1;
        check("mid_rst_game_rst", 32'(game_rst), 32'd1);
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_cfg", 32'({control, i_value}), 32'd0);
        check("mid_rst_tallies", 32'({win_tally, lose_tally}), 32'd0);
        check("mid_rst_no_res", 32'(res_cnt - r0), 32'd0);
        q_res.delete();
        q_init.delete();
        for (int i = 0; i < NS; i++) begin m_ctrl[i] = '0; m_val[i] = '0; end
        rst_l = 1'b1;
        tick();
        run_seq(2, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
